// File: rtl/sub6_pkg.sv
// sub6_pkg: shared constants and FSM state type for the sub6 subtraction stage.
package sub6_pkg;

    // Default operand/result width of the subtractor stage.
    localparam int SUB6_WIDTH = 6;

    // Handshake FSM: wait for operands, compute, hold result for downstream.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } sub6_state_t;

endpackage : sub6_pkg

// File: rtl/sub6_core.sv
// sub6_core: purely combinational WIDTH-bit ripple-borrow subtractor built
// from one full-subtractor cell per bit. diff = a - b - bin (mod 2^WIDTH).
module sub6_core
    import sub6_pkg::*;
#(
    parameter int WIDTH = SUB6_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // brw[i] is the borrow into bit i; brw[WIDTH] is the borrow out of the MSB.
    logic [WIDTH:0] brw;

    assign brw[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        // Full subtractor: difference bit and borrow to the next bit.
        assign diff[i]  = a[i] ^ b[i] ^ brw[i];
        assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end

    assign bout = brw[WIDTH];

endmodule : sub6_core

// File: rtl/sub6_stage.sv
// sub6_stage: registered, handshaked subtraction stage around sub6_core.
// Operands are captured on the input handshake, the result (diff, borrow_out
// and optional flags) is registered one cycle later and held until the
// downstream handshake completes.
// Optional feature macro: SUB6_FLAGS_EN (zero/ovf flag computation). When it
// is undefined the zero and ovf ports are tied to 0.
module sub6_stage
    import sub6_pkg::*;
#(
    parameter int WIDTH = SUB6_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             ovf
);

    sub6_state_t state_q;
    sub6_state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_c;
    logic             bout_c;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic accept;
    logic capture;

    // A flush on the accept cycle discards the pair; a flush in EXEC
    // leaves the previous result registers untouched.
    assign accept  = (state_q == IDLE) && in_valid && !flush;
    assign capture = (state_q == EXEC) && !flush;

    // Outputs decoded from the state register only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid)  state_d = EXEC;
                EXEC:                   state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default:                state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- Stage boundary: operand capture on the input handshake ----
    // Operand registers hold the pair stable while the ripple chain settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Ripple-borrow subtractor; the LSB borrow-in is always zero.
    sub6_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (a_q),
        .b    (b_q),
        .bin  (1'b0),
        .diff (diff_c),
        .bout (bout_c)
    );

    // ---- Stage boundary: result capture at the end of EXEC ----
    // Result registers stay stable through DONE and across flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (capture) begin
            diff_q   <= diff_c;
            borrow_q <= bout_c;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;

`ifdef SUB6_FLAGS_EN
    logic zero_q;
    logic ovf_q;

    // Zero flag: every result bit clear.
    function automatic logic calc_zero(input logic [WIDTH-1:0] d);
        return (d == '0);
    endfunction

    // Signed overflow: operands differ in sign and the result sign
    // differs from the minuend sign.
    function automatic logic calc_ovf(input logic sa, input logic sb, input logic sd);
        return (sa ^ sb) & (sa ^ sd);
    endfunction

    // Flag registers captured together with diff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (capture) begin
            zero_q <= calc_zero(diff_c);
            ovf_q  <= calc_ovf(a_q[WIDTH-1], b_q[WIDTH-1], diff_c[WIDTH-1]);
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule : sub6_stage
